// File: rtl/hex_disp_scan.sv
// Time-multiplexed common-anode hex display scanner.
// Round-robin digit slots with an anti-ghost blank, blink and LZ blanking.
module hex_disp_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_blank,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel_n
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_lz;

  logic [IW-1:0] idx;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  allz;
  logic                  blank;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Walk down from the top digit; a digit is a leading zero while
  // everything from it upward is zero. Digit 0 is never suppressed.
  always_comb begin
    lz_mask = '0;
    allz    = sh_lz;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = sh_value[4*i +: 4];
    end
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      allz       = allz & (nib[i] == 4'h0);
      lz_mask[i] = allz;
    end
  end

  assign blank = ~sh_en[idx]
               | (sh_blink[idx] & blink_off)
               | lz_mask[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value <= '0;
      sh_en    <= '0;
      sh_blink <= '0;
      sh_lz    <= 1'b0;
    end else if (load) begin
      sh_value <= value;
      sh_en    <= dig_en;
      sh_blink <= blink_en;
      sh_lz    <= lz_blank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      scan_cnt <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Slot cycle 0 stays dark so the previous digit's segments drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out   <= 7'h7F;
      dig_sel_n <= '1;
    end else if (scan_cnt == '0 || blank) begin
      seg_out   <= 7'h7F;
      dig_sel_n <= '1;
    end else begin
      seg_out   <= hex_seg(nib[idx]);
      dig_sel_n <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_hex_disp_scan.sv
// Randomized bench for hex_disp_scan against a cycle-count based model.
// Expected outputs derive from elapsed edges and captured shadow state.
module tb_hex_disp_scan;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BC = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dig_en = '0;
  logic [3:0]  blink_en = '0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg_out;
  logic [3:0]  dig_sel_n;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  bit found;

  logic [15:0] m_val;
  logic [3:0]  m_en;
  logic [3:0]  m_bl;
  logic        m_lz;
  logic [6:0]  e_seg;
  logic [3:0]  e_dig;

  logic [6:0]  seg_tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

  always #5 clk = ~clk;

  hex_disp_scan #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (SD),
    .BLINK_CYCLES(BC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .dig_en   (dig_en),
    .blink_en (blink_en),
    .lz_blank (lz_blank),
    .seg_out  (seg_out),
    .dig_sel_n(dig_sel_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Output after the next edge reflects the state reached after k edges.
  task automatic model();
    int  scan, id;
    bit  off, blk;
    scan = k % SD;
    id   = (k / SD) % N;
    off  = ((k / BC) % 2) == 1;
    blk  = !m_en[id] || (m_bl[id] && off) ||
           (m_lz && id > 0 && (m_val >> (4 * id)) == 16'h0);
    if (scan == 0 || blk) begin
      e_seg = 7'h7F;
      e_dig = 4'hF;
    end else begin
      e_seg = seg_tbl[(m_val >> (4 * id)) & 16'hF];
      e_dig = ~(4'b0001 << id);
    end
  endtask

  task automatic step();
    model();
    if (load) begin
      m_val = value;
      m_en  = dig_en;
      m_bl  = blink_en;
      m_lz  = lz_blank;
    end
    @(posedge clk);
    #1;
    k++;
    load = 1'b0;
    chk("seg", {25'd0, seg_out}, {25'd0, e_seg});
    chk("dig", {28'd0, dig_sel_n}, {28'd0, e_dig});
    chk("onehot", $countones(~dig_sel_n) <= 1, 1);
    chk("darkoff", (dig_sel_n == 4'hF) && (seg_out != 7'h7F), 0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en,
                         input logic [3:0] bl, input logic lz);
    value    = v;
    dig_en   = en;
    blink_en = bl;
    lz_blank = lz;
    load     = 1'b1;
    step();
  endtask

  task automatic model_reset();
    k     = 0;
    m_val = '0;
    m_en  = '0;
    m_bl  = '0;
    m_lz  = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_seg", {25'd0, seg_out}, 32'h7F);
    chk("rst_dig", {28'd0, dig_sel_n}, 32'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    run(3);
    do_load(16'h12AF, 4'hF, 4'h0, 1'b0);
    run(40);

    do_load(16'h0050, 4'hF, 4'h0, 1'b1);
    run(34);
    do_load(16'h0000, 4'hF, 4'h0, 1'b1);
    run(34);

    do_load(16'h8888, 4'hF, 4'b0010, 1'b0);
    run(300);

    do_load(16'h4321, 4'b0101, 4'h0, 1'b0);
    for (int i = 0; i < 3 * N * SD; i++) begin
      step();
      chk("no_d1", dig_sel_n == 4'b1101, 0);
      chk("no_d3", dig_sel_n == 4'b0111, 0);
    end

    do_load(16'h1234, 4'hF, 4'h0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (dig_sel_n == 4'b1011) found = 1'b1;
    end
    chk("find_d2", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", {25'd0, seg_out}, 32'h7F);
    chk("arst_dig", {28'd0, dig_sel_n}, 32'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    value  = 16'hFFFF;
    dig_en = 4'hF;
    run(20);
    chk("post_rst", {25'd0, seg_out}, 32'h7F);

    do_load(16'h1111, 4'hF, 4'h0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (dig_sel_n == 4'b1101) found = 1'b1;
    end
    chk("find_d1", found, 1);
    do_load(16'h2222, 4'hF, 4'h0, 1'b0);
    step();
    chk("ld_mid_seg", {25'd0, seg_out}, 32'h24);
    chk("ld_mid_dig", {28'd0, dig_sel_n}, 32'hD);
    run(20);

    for (int r = 0; r < 25; r++) begin
      do_load(16'($urandom) & masks[$urandom_range(0, 4)],
              4'($urandom), 4'($urandom), 1'($urandom));
      run($urandom_range(5, 60));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_disp_scan.md
Name: hex_disp_scan

Overview:
Parametrised, time-multiplexed 7-segment display controller for NUM_DIGITS hex digits sharing one segment bus.
- Captures a multi-digit hex value plus per-digit enable and blink masks on a load strobe.
- Scans the digits round-robin with one blanked anti-ghosting cycle per slot.
- Supports per-digit blink and leading-zero suppression.
- Sits between game/score logic and the board's common-anode digit drivers.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
SCAN_DIV, 50000, clock cycles per digit slot; must be >= 2.
BLINK_CYCLES, 25000000, clock cycles per blink half-period; must be >= 1.

Ports:
clk  in  1  single system clock, all logic on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
load  in  1  single-cycle strobe; captures value/dig_en/blink_en/lz_blank.
value  in  4*NUM_DIGITS  hex nibbles; nibble i = value[4i+3:4i]; digit 0 is least significant.
dig_en  in  NUM_DIGITS  per-digit enable; 0 = digit always blank.
blink_en  in  NUM_DIGITS  per-digit blink; 1 = blank during blink off-phase.
lz_blank  in  1  1 = suppress leading zeros.
seg_out  out  7  active-low segments {g,f,e,d,c,b,a}; 7'h7F = all off.
dig_sel_n  out  NUM_DIGITS  active-low one-hot digit select; all ones = none driven.

Behaviour:
Reset:
- One clock, clk. rst_n is asynchronous and active-low.
- While rst_n = 0: seg_out = 7'h7F; dig_sel_n = all ones; shadow value/dig_en/blink_en/lz_blank = 0; idx = 0; scan_cnt = 0; blink_cnt = 0; blink_phase = ON.
- Reset mid-operation forces these values immediately, not at the next edge.

Capture:
- load = 1 at a rising edge writes all four shadow registers together from the inputs.
- load = 0 holds the shadow registers.
- A load does not disturb the scan or blink counters.

Scan:
- scan_cnt counts 0..SCAN_DIV-1 and wraps.
- idx increments at the edge where scan_cnt = SCAN_DIV-1, wrapping from NUM_DIGITS-1 to 0.
- Slot for digit k = the SCAN_DIV cycles with idx = k.

Blink:
- blink_cnt counts 0..BLINK_CYCLES-1.
- At the wrap, blink_phase toggles ON <-> OFF.
- Blink runs independently of the scan.

Digit i is blanked if any of the following holds:
- dig_en[i] = 0.
- blink_en[i] = 1 and blink_phase = OFF.
- lz_blank = 1, i > 0, and nibbles i..NUM_DIGITS-1 are all zero.
- Digit 0 is never blanked by leading-zero suppression.

Outputs (registered, 1-cycle latency: output in cycle t+1 reflects idx/scan_cnt/shadow/phase in cycle t):
- If scan_cnt = 0 (anti-ghost cycle): seg_out = 7'h7F, dig_sel_n = all ones.
- Else if digit idx is blanked: seg_out = 7'h7F, dig_sel_n = all ones.
- Else: dig_sel_n has bit idx = 0 and all others 1; seg_out = decode(nibble idx).
- Resulting timing: each visible digit is driven SCAN_DIV-1 cycles per slot.
- Full frame = NUM_DIGITS*SCAN_DIV cycles.

Decode (hex):
- 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
- 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E

Invariants:
- dig_sel_n never has more than one zero bit.
- seg_out = 7'h7F whenever dig_sel_n = all ones.

Load mid-slot:
- The new shadow contents appear on the outputs one cycle after the load edge.
- No glitch to other digits.

Test Plan:
Params NUM_DIGITS=4, SCAN_DIV=4, BLINK_CYCLES=64 for all scenarios.
1. Reset, then load value=16'h12AF, dig_en=4'hF, blink_en=0, lz_blank=0 -> per slot, 1 blank cycle then 3 cycles of: dig_sel_n=4'b1110/seg 0E, then 4'b1101/seg 08, then 4'b1011/seg 24, then 4'b0111/seg 79; frame repeats every 16 cycles.
2. Load value=16'h0050, lz_blank=1, dig_en=4'hF -> digits 3 and 2 blank (dig_sel_n=4'hF, seg 7F); digit 1 shows 12; digit 0 shows 40. Then value=16'h0000 -> only digit 0 shows 40.
3. blink_en=4'b0010, value=16'h8888 -> digit 1 visible for 64 cycles, blank for 64, repeating; digits 0, 2, 3 unaffected (seg 00).
4. dig_en=4'b0101 -> digits 1 and 3 never selected; dig_sel_n never 4'b1101 or 4'b0111 over 3 frames.
5. Assert rst_n=0 asynchronously mid-slot while digit 2 is driven -> seg_out=7F and dig_sel_n=4'hF with no clock edge. After release, everything stays blank until the next load.
6. Load value 16'h1111 -> 16'h2222 while digit 1 is driven -> the next cycle shows 24 on digit 1; idx and scan_cnt continue without restart; one-hot invariant asserted throughout.
